// File: rtl/sot_capture_fifo_mc.sv
// sot_capture_fifo_mc
//   Multi-channel start-of-trigger capture FIFO for bitslip alignment.
//   Each channel stores the non-zero words it sees during a capture session,
//   shows the newest word on data_out, and raises locked once the same word
//   has repeated LOCK_CNT times. A single pop port returns any channel's
//   history oldest-first.
//   Optional macro SOT_HOLD_ON_DISABLE_EN: dropping bitslip_ena freezes the
//   channels, which stay poppable. The clear happens once, when the enable
//   rises again. Without the macro, a low enable clears every cycle.
module sot_capture_fifo_mc #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 4,
   parameter int N_CH     = 1,
   parameter int LOCK_CNT = 8,
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   S_AXI_ACLK,
   input  logic                   S_AXI_ARESETN,
   input  logic                   bitslip_ena,
   input  logic [N_CH*DATA_W-1:0] data_in_sot,
   output logic [N_CH*DATA_W-1:0] data_out,
   output logic [N_CH*CNT_W-1:0]  fill_level,
   output logic [N_CH-1:0]        full,
   output logic [N_CH-1:0]        overflow,
   output logic [N_CH-1:0]        locked,
   input  logic                   rd_en,
   input  logic [CH_W-1:0]        rd_ch,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);
   localparam logic [7:0]       LOCK_MAX = 8'(LOCK_CNT);
   localparam logic [CH_W:0]    N_CH_L   = N_CH[CH_W:0];

   logic [DATA_W-1:0] mem      [N_CH][DEPTH];
   logic [PTR_W-1:0]  head     [N_CH];
   logic [PTR_W-1:0]  tail     [N_CH];
   logic [CNT_W-1:0]  fill_q   [N_CH];
   logic [DATA_W-1:0] last_q   [N_CH];
   logic [7:0]        lock_q   [N_CH];
   logic [N_CH-1:0]   full_q, ovf_q, locked_q;

   logic              clear, wr_allow, ch_ok;
   logic [DATA_W-1:0] word     [N_CH];
   logic [N_CH-1:0]   push, pop;
   logic [CNT_W-1:0]  fill_nxt [N_CH];
   logic [7:0]        lock_nxt [N_CH];
   logic [DATA_W-1:0] pop_word;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef SOT_HOLD_ON_DISABLE_EN
   logic ena_q;

   // Previous enable, so a new capture session clears exactly once
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) ena_q <= 1'b0;
      else                ena_q <= bitslip_ena;
   end

   assign clear    = bitslip_ena & ~ena_q;
   assign wr_allow = bitslip_ena &  ena_q;
`else
   assign clear    = ~bitslip_ena;
   assign wr_allow = bitslip_ena;
`endif

   // Per-channel push/pop decode, next fill level and next lock count
   always_comb begin
      // NOTE: every comb output gets a default before any branch, so no latch is inferred.
      ch_ok    = ({1'b0, rd_ch} < N_CH_L);
      pop_word = '0;
      for (int c = 0; c < N_CH; c++) begin
         word[c] = data_in_sot[c*DATA_W +: DATA_W];
         push[c] = wr_allow && (word[c] != '0);
         pop[c]  = rd_en && ch_ok && (rd_ch == CH_W'(c)) && (fill_q[c] != '0);
         if (pop[c]) pop_word = mem[c][head[c]];

         fill_nxt[c] = fill_q[c];
         if (push[c] && !pop[c] && (fill_q[c] != FILL_MAX))
            fill_nxt[c] = fill_q[c] + CNT_W'(1);
         else if (pop[c] && !push[c])
            fill_nxt[c] = fill_q[c] - CNT_W'(1);

         lock_nxt[c] = lock_q[c];
         if (push[c]) begin
            if ((word[c] == last_q[c]) && (lock_q[c] != '0))
               lock_nxt[c] = (lock_q[c] == LOCK_MAX) ? LOCK_MAX : lock_q[c] + 8'd1;
            else
               lock_nxt[c] = 8'd1;
         end
      end
   end

   // Pack per-channel registers onto the flat output buses
   always_comb begin
      data_out   = '0;
      fill_level = '0;
      for (int c = 0; c < N_CH; c++) begin
         data_out[c*DATA_W +: DATA_W]  = last_q[c];
         fill_level[c*CNT_W +: CNT_W] = fill_q[c];
      end
   end

   assign full     = full_q;
   assign overflow = ovf_q;
   assign locked   = locked_q;

   // Capture, drop-oldest, pop and lock state for every channel
   always_ff @(posedge S_AXI_ACLK) begin
      // NOTE: non-blocking assignments here, so every register sees pre-edge values.
      if (!S_AXI_ARESETN || clear) begin
         for (int c = 0; c < N_CH; c++) begin
            // NOTE: the storage is cleared too, because a new session must never replay stale words.
            for (int i = 0; i < DEPTH; i++) mem[c][i] <= '0;
            head[c]   <= '0;
            tail[c]   <= '0;
            fill_q[c] <= '0;
            last_q[c] <= '0;
            lock_q[c] <= '0;
         end
         full_q   <= '0;
         ovf_q    <= '0;
         locked_q <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (push[c]) begin
               mem[c][tail[c]] <= word[c];
               tail[c]         <= ptr_inc(tail[c]);
               last_q[c]       <= word[c];
            end
            // The head moves on a pop, or when a push into a full channel drops the oldest entry
            if (pop[c] || (push[c] && (fill_q[c] == FILL_MAX)))
               head[c] <= ptr_inc(head[c]);
            if (push[c] && !pop[c] && (fill_q[c] == FILL_MAX))
               ovf_q[c] <= 1'b1;
            fill_q[c]   <= fill_nxt[c];
            full_q[c]   <= (fill_nxt[c] == FILL_MAX);
            lock_q[c]   <= lock_nxt[c];
            locked_q[c] <= (lock_nxt[c] == LOCK_MAX);
         end
         if (rd_en) begin
            rd_valid <= |pop;
            rd_data  <= pop_word;
         end else begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sot_capture_fifo_mc.sv
// tb_sot_capture_fifo_mc
//   Directed and random stimulus for sot_capture_fifo_mc with 3 channels,
//   DEPTH=4 and LOCK_CNT=8. A queue-based reference model predicts every
//   output after each clock edge. The model follows SOT_HOLD_ON_DISABLE_EN
//   when it is defined.
module tb_sot_capture_fifo_mc;
   localparam int DATA_W   = 8;
   localparam int DEPTH    = 4;
   localparam int N_CH     = 3;
   localparam int LOCK_CNT = 8;
   localparam int CNT_W    = $clog2(DEPTH + 1);
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                   S_AXI_ACLK    = 1'b0;
   logic                   S_AXI_ARESETN = 1'b0;
   logic                   bitslip_ena   = 1'b0;
   logic [N_CH*DATA_W-1:0] data_in_sot   = '0;
   logic                   rd_en         = 1'b0;
   logic [CH_W-1:0]        rd_ch         = '0;
   logic [N_CH*DATA_W-1:0] data_out;
   logic [N_CH*CNT_W-1:0]  fill_level;
   logic [N_CH-1:0]        full, overflow, locked;
   logic [DATA_W-1:0]      rd_data;
   logic                   rd_valid;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] mq [N_CH][$];
   int m_dout [N_CH];
   int m_ovf  [N_CH];
   int m_cnt  [N_CH];
   int m_rdd  = 0;
   int m_rdv  = 0;
   int m_prev = 0;

   sot_capture_fifo_mc #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH), .LOCK_CNT(LOCK_CNT)
   ) dut (
      .S_AXI_ACLK   (S_AXI_ACLK),
      .S_AXI_ARESETN(S_AXI_ARESETN),
      .bitslip_ena  (bitslip_ena),
      .data_in_sot  (data_in_sot),
      .data_out     (data_out),
      .fill_level   (fill_level),
      .full         (full),
      .overflow     (overflow),
      .locked       (locked),
      .rd_en        (rd_en),
      .rd_ch        (rd_ch),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid)
   );

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N_CH*DATA_W-1:0] w3(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c);
      return {c, b, a};
   endfunction

   // Model of one clock edge, from the behavioural rules
   task automatic model_edge(input logic rst_n, input logic ena, input logic re, input int ch,
                             input logic [N_CH*DATA_W-1:0] din);
      bit clr, wr;
      logic [7:0] w;
`ifdef SOT_HOLD_ON_DISABLE_EN
      clr    = !rst_n || (ena && (m_prev == 0));
      wr     = ena && !clr;
      m_prev = rst_n ? int'(ena) : 0;
`else
      clr = !rst_n || !ena;
      wr  = 1'b1;
`endif
      if (clr) begin
         for (int c = 0; c < N_CH; c++) begin
            mq[c].delete();
            m_dout[c] = 0;
            m_ovf[c]  = 0;
            m_cnt[c]  = 0;
         end
         m_rdd = 0;
         m_rdv = 0;
         return;
      end
      if (re) begin
         if (ch < N_CH && mq[ch].size() > 0) begin
            m_rdd = int'(mq[ch].pop_front());
            m_rdv = 1;
         end else begin
            m_rdd = 0;
            m_rdv = 0;
         end
      end else begin
         m_rdv = 0;
      end
      if (wr) begin
         for (int c = 0; c < N_CH; c++) begin
            w = din[c*DATA_W +: DATA_W];
            if (w != 8'h00) begin
               if (mq[c].size() == DEPTH) begin
                  mq[c].delete(0);
                  m_ovf[c] = 1;
               end
               mq[c].push_back(w);
               if (int'(w) == m_dout[c] && m_cnt[c] != 0)
                  m_cnt[c] = (m_cnt[c] < LOCK_CNT) ? m_cnt[c] + 1 : LOCK_CNT;
               else
                  m_cnt[c] = 1;
               m_dout[c] = int'(w);
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int c = 0; c < N_CH; c++) begin
         check($sformatf("%s.dout%0d", tag, c), 32'(data_out[c*DATA_W +: DATA_W]), m_dout[c]);
         check($sformatf("%s.fill%0d", tag, c), 32'(fill_level[c*CNT_W +: CNT_W]), mq[c].size());
         check($sformatf("%s.full%0d", tag, c), 32'(full[c]), 32'(mq[c].size() == DEPTH));
         check($sformatf("%s.ovf%0d", tag, c), 32'(overflow[c]), m_ovf[c]);
         check($sformatf("%s.lock%0d", tag, c), 32'(locked[c]), 32'(m_cnt[c] == LOCK_CNT));
      end
      check($sformatf("%s.rd_valid", tag), 32'(rd_valid), m_rdv);
      check($sformatf("%s.rd_data", tag), 32'(rd_data), m_rdd);
   endtask

   // Drive one cycle of inputs, let the edge happen, then check against the model
   task automatic step(input logic rst_n, input logic ena, input logic re, input int ch,
                       input logic [N_CH*DATA_W-1:0] din, input string tag);
      S_AXI_ARESETN = rst_n;
      bitslip_ena   = ena;
      rd_en         = re;
      rd_ch         = CH_W'(ch);
      data_in_sot   = din;
      @(posedge S_AXI_ACLK);
      #1;
      model_edge(rst_n, ena, re, ch, din);
      check_all(tag);
   endtask

   // Start a fresh session: clear, then one idle enabled cycle
   task automatic restart(input string tag);
      step(1'b1, 1'b0, 1'b0, 0, '0, {tag, "_clr"});
      step(1'b1, 1'b1, 1'b0, 0, '0, {tag, "_idle"});
   endtask

   initial begin
      logic [7:0] rw [N_CH];
      logic       r_rst, r_ena, r_re;
      int         r_ch;

      // Reset
      step(1'b0, 1'b0, 1'b0, 0, '0, "rst0");
      step(1'b0, 1'b1, 1'b0, 0, '0, "rst1");
      check("rst_dout", 32'(data_out), 0);
      check("rst_fill", 32'(fill_level), 0);
      step(1'b1, 1'b1, 1'b0, 0, '0, "t1_idle");

      // Test 1: zeros ignored, pops oldest-first
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h00, 0, 0), "t1_w0");
      step(1'b1, 1'b1, 1'b0, 0, w3(8'hA5, 0, 0), "t1_w1");
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h00, 0, 0), "t1_w2");
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h3C, 0, 0), "t1_w3");
      check("t1_fill", 32'(fill_level[0 +: CNT_W]), 2);
      check("t1_dout", 32'(data_out[7:0]), 32'h3C);
      check("t1_ovf", 32'(overflow[0]), 0);
      step(1'b1, 1'b1, 1'b1, 0, '0, "t1_p0");
      check("t1_pop0", 32'(rd_data), 32'hA5);
      step(1'b1, 1'b1, 1'b1, 0, '0, "t1_p1");
      check("t1_pop1", 32'(rd_data), 32'h3C);
      step(1'b1, 1'b1, 1'b1, 0, '0, "t1_p2");
      check("t1_pop_empty", 32'(rd_valid), 0);

      // Test 2: overflow drops the oldest entries
      restart("t2");
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 1'b0, 0, w3(0, 8'(i), 0), "t2_w");
      check("t2_fill", 32'(fill_level[CNT_W +: CNT_W]), 4);
      check("t2_full", 32'(full[1]), 1);
      check("t2_ovf", 32'(overflow[1]), 1);
      for (int i = 3; i <= 6; i++) begin
         step(1'b1, 1'b1, 1'b1, 1, '0, "t2_p");
         check("t2_pop", 32'(rd_data), i);
      end

      // Test 3: lock after LOCK_CNT repeats, zeros in between do not break it
      restart("t3");
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, 1'b0, 0, w3(8'h5A, 0, 0), "t3_w");
         step(1'b1, 1'b1, 1'b0, 0, '0, "t3_z");
      end
      check("t3_lock7", 32'(locked[0]), 0);
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h5A, 0, 0), "t3_w8");
      check("t3_lock8", 32'(locked[0]), 1);
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h5B, 0, 0), "t3_5b");
      check("t3_unlock", 32'(locked[0]), 0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 0, w3(8'h5B, 0, 0), "t3_5b_rep");
      check("t3_relock", 32'(locked[0]), 1);

      // Test 4: channel independence and out-of-range pop channel
      restart("t4");
      step(1'b1, 1'b1, 1'b0, 0, w3(0, 0, 8'h77), "t4_w");
      check("t4_fill2", 32'(fill_level[2*CNT_W +: CNT_W]), 1);
      check("t4_fill0", 32'(fill_level[0 +: CNT_W]), 0);
      step(1'b1, 1'b1, 1'b1, 3, '0, "t4_badch");
      check("t4_badch_valid", 32'(rd_valid), 0);

      // Test 5: simultaneous push and pop on full and empty channels
      restart("t5");
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 0, w3(8'(i), 0, 0), "t5_fill");
      step(1'b1, 1'b1, 1'b1, 0, w3(8'h99, 0, 0), "t5_full_pp");
      check("t5_old_head", 32'(rd_data), 1);
      check("t5_fill_kept", 32'(fill_level[0 +: CNT_W]), 4);
      check("t5_no_ovf", 32'(overflow[0]), 0);
      step(1'b1, 1'b1, 1'b1, 1, w3(0, 8'h55, 0), "t5_empty_pp");
      check("t5_empty_valid", 32'(rd_valid), 0);
      check("t5_empty_fill", 32'(fill_level[CNT_W +: CNT_W]), 1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 0, '0, "t5_drain");

      // Test 6: reset mid-capture, then enable drop and re-raise
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h11, 8'h22, 8'h33), "t6_w");
      step(1'b0, 1'b1, 1'b0, 0, w3(8'h44, 0, 0), "t6_rst");
      check("t6_rst_dout", 32'(data_out), 0);
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h11, 8'h22, 0), "t6_w1");
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h12, 0, 0), "t6_w2");
      step(1'b1, 1'b0, 1'b0, 0, w3(8'h13, 0, 0), "t6_drop");
      step(1'b1, 1'b0, 1'b1, 0, '0, "t6_pop_dis");
      step(1'b1, 1'b0, 1'b0, 0, '0, "t6_hold");
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h66, 0, 0), "t6_rise");
      step(1'b1, 1'b1, 1'b0, 0, w3(8'h67, 0, 0), "t6_after");

      // Random phase
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < N_CH; c++) begin
            case ($urandom_range(0, 3))
               0:       rw[c] = 8'h00;
               1, 2:    rw[c] = 8'h5A;
               default: rw[c] = 8'($urandom);
            endcase
         end
         r_rst = ($urandom_range(0, 99) != 0);
         r_ena = ($urandom_range(0, 19) != 0);
         r_re  = 1'($urandom_range(0, 1));
         r_ch  = $urandom_range(0, 3);
         step(r_rst, r_ena, r_re, r_ch, w3(rw[0], rw[1], rw[2]), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
